// File: rtl/mem_burst_master_module_pkg.sv
// Shared definitions for the cache-line burst master: FSM states, burst encodings
// and line/beat geometry.
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 32
`endif

package mem_burst_master_module_pkg;

  localparam int LINE_W      = 512;
  localparam int BEAT_W      = 128;
  localparam int LINE_MASK_W = 64;
  localparam int BEAT_MASK_W = 16;

  localparam logic [2:0] BURST_4  = 3'b011;
  localparam logic [2:0] SIZE_16B = 3'b100;

  // IDLE must stay at zero: the state register resets to all-zeros.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RSP     = 3'd4
  } burst_state_e;

endpackage

// File: rtl/mem_burst_master_module_dff.sv
// Generic load-enable flops: gnrl_dfflr carries a synchronous active-high reset
// for control state, gnrl_dffl has no reset and is used for data capture.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end
endmodule

module gnrl_dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk) begin
    if (lden) begin
      qout <= dnxt;
    end
  end
endmodule

// File: rtl/mem_burst_master_module_rd_asm.sv
// Read-line assembler: writes each returned 128-bit beat into its slot of the
// 512-bit line selected by the beat index.
module mem_burst_rd_asm
  import mem_burst_master_module_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [1:0]        i_idx,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [LINE_W-1:0] o_line
);
  localparam int NBEATS = LINE_W / BEAT_W;

  for (genvar g = 0; g < NBEATS; g++) begin : g_beat
    gnrl_dffl #(.DW(BEAT_W)) u_beat (
      .clk  (clk),
      .lden (i_we && (i_idx == 2'(g))),
      .dnxt (i_beat),
      .qout (o_line[g*BEAT_W +: BEAT_W])
    );
  end
endmodule

// File: rtl/mem_burst_master_module.sv
// Cache-line burst master: turns one 64-byte refill/writeback request into a
// 4-beat x 16-byte external burst and returns a single completion.
module mem_burst_master_module
  import mem_burst_master_module_pkg::*;
#(
  parameter int ADDR_WIDTH = `PHY_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_vld,
  input  logic                   i_req_wr,
  input  logic [ADDR_WIDTH-1:0]  i_req_paddr,
  input  logic [LINE_W-1:0]      i_req_wdat,
  input  logic [LINE_MASK_W-1:0] i_req_mask,
  output logic                   o_req_rdy,
  output logic                   o_rsp_vld,
  output logic                   o_rsp_wr,
  output logic [LINE_W-1:0]      o_rsp_rdat,
  input  logic                   i_rsp_rdy,
  output logic                   o_mem_ext_rden,
  output logic                   o_mem_ext_wren,
  output logic                   o_mem_ext_burst_start,
  output logic                   o_mem_ext_burst_end,
  output logic                   o_mem_ext_burst_vld,
  output logic [BEAT_MASK_W-1:0] o_mem_ext_mask,
  output logic [2:0]             o_mem_ext_burst,
  output logic [2:0]             o_mem_ext_burst_size,
  output logic [ADDR_WIDTH-1:0]  o_mem_ext_paddr,
  output logic [BEAT_W-1:0]      o_mem_ext_wdat,
  input  logic                   i_ext_mmu_rdy,
  input  logic                   i_ext_mmu_rd_ack,
  input  logic                   i_ext_mmu_wr_ack,
  input  logic [BEAT_W-1:0]      i_ext_mmu_rdat
);

  burst_state_e           state_q, state_d;
  logic [2:0]             state_raw_q;
  logic [1:0]             cnt_q, cnt_d;
  logic                   wr_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [LINE_W-1:0]      wdat_q;
  logic [LINE_MASK_W-1:0] mask_q;
  logic [LINE_W-1:0]      rd_line;
  logic                   accept, asm_we, in_issue, first_beat;

  // Held low during reset so nothing is accepted on the reset edge.
  assign o_req_rdy = (state_q == ST_IDLE) && i_ext_mmu_rdy && !rst;
  assign accept    = o_req_rdy && i_req_vld;

  gnrl_dfflr #(.DW(3)) u_state (
    .clk(clk), .rst(rst), .lden(1'b1), .dnxt(state_d), .qout(state_raw_q)
  );
  assign state_q = burst_state_e'(state_raw_q);

  gnrl_dfflr #(.DW(2)) u_cnt (
    .clk(clk), .rst(rst), .lden(1'b1), .dnxt(cnt_d), .qout(cnt_q)
  );
  gnrl_dfflr #(.DW(1)) u_wr (
    .clk(clk), .rst(rst), .lden(accept), .dnxt(i_req_wr), .qout(wr_q)
  );

  gnrl_dffl #(.DW(ADDR_WIDTH)) u_paddr (
    .clk(clk), .lden(accept),
    .dnxt(i_req_paddr & ~ADDR_WIDTH'(6'h3f)), .qout(paddr_q)
  );
  gnrl_dffl #(.DW(LINE_W)) u_wdat (
    .clk(clk), .lden(accept), .dnxt(i_req_wdat), .qout(wdat_q)
  );
  gnrl_dffl #(.DW(LINE_MASK_W)) u_mask (
    .clk(clk), .lden(accept), .dnxt(i_req_mask), .qout(mask_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          cnt_d   = 2'd0;
        end
      end
      ST_ISSUE: begin
        // Beats are never stalled; the counter wraps 3->0 on leaving ISSUE.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = wr_q ? ST_WR_WAIT : ST_RD_DATA;
      end
      ST_WR_WAIT: begin
        if (i_ext_mmu_wr_ack) state_d = ST_RSP;
      end
      ST_RD_DATA: begin
        if (i_ext_mmu_rd_ack) begin
          asm_we = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_rdy) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  mem_burst_rd_asm u_rd_asm (
    .clk    (clk),
    .i_we   (asm_we),
    .i_idx  (cnt_q),
    .i_beat (i_ext_mmu_rdat),
    .o_line (rd_line)
  );

  assign in_issue   = (state_q == ST_ISSUE);
  assign first_beat = in_issue && (cnt_q == 2'd0);

  assign o_mem_ext_burst_vld   = in_issue;
  assign o_mem_ext_burst_start = first_beat;
  assign o_mem_ext_burst_end   = in_issue && (cnt_q == 2'd3);
  assign o_mem_ext_rden        = first_beat && !wr_q;
  assign o_mem_ext_wren        = first_beat && wr_q;
  assign o_mem_ext_burst       = in_issue ? BURST_4 : 3'b000;
  assign o_mem_ext_burst_size  = in_issue ? SIZE_16B : 3'b000;
  assign o_mem_ext_paddr       = in_issue ? (paddr_q | ADDR_WIDTH'({cnt_q, 4'b0000})) : '0;
  assign o_mem_ext_wdat        = (in_issue && wr_q) ? wdat_q[BEAT_W*cnt_q +: BEAT_W] : '0;
  assign o_mem_ext_mask        = (in_issue && wr_q) ? mask_q[BEAT_MASK_W*cnt_q +: BEAT_MASK_W] : '0;

  assign o_rsp_vld  = (state_q == ST_RSP);
  assign o_rsp_wr   = (state_q == ST_RSP) && wr_q;
  assign o_rsp_rdat = ((state_q == ST_RSP) && !wr_q) ? rd_line : '0;

endmodule

// File: tb/tb_mem_burst_master_module.sv
// Self-checking bench for mem_burst_master_module: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_burst_master_module;

  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_req_vld, i_req_wr;
  logic [AW-1:0]  i_req_paddr;
  logic [511:0]   i_req_wdat;
  logic [63:0]    i_req_mask;
  logic           o_req_rdy;
  logic           o_rsp_vld, o_rsp_wr;
  logic [511:0]   o_rsp_rdat;
  logic           i_rsp_rdy;
  logic           o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_burst_start;
  logic           o_mem_ext_burst_end, o_mem_ext_burst_vld;
  logic [15:0]    o_mem_ext_mask;
  logic [2:0]     o_mem_ext_burst, o_mem_ext_burst_size;
  logic [AW-1:0]  o_mem_ext_paddr;
  logic [127:0]   o_mem_ext_wdat;
  logic           i_ext_mmu_rdy, i_ext_mmu_rd_ack, i_ext_mmu_wr_ack;
  logic [127:0]   i_ext_mmu_rdat;

  int n_cmp = 0;
  int n_bad = 0;

  mem_burst_master_module #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_vld(i_req_vld), .i_req_wr(i_req_wr), .i_req_paddr(i_req_paddr),
    .i_req_wdat(i_req_wdat), .i_req_mask(i_req_mask), .o_req_rdy(o_req_rdy),
    .o_rsp_vld(o_rsp_vld), .o_rsp_wr(o_rsp_wr), .o_rsp_rdat(o_rsp_rdat), .i_rsp_rdy(i_rsp_rdy),
    .o_mem_ext_rden(o_mem_ext_rden), .o_mem_ext_wren(o_mem_ext_wren),
    .o_mem_ext_burst_start(o_mem_ext_burst_start), .o_mem_ext_burst_end(o_mem_ext_burst_end),
    .o_mem_ext_burst_vld(o_mem_ext_burst_vld), .o_mem_ext_mask(o_mem_ext_mask),
    .o_mem_ext_burst(o_mem_ext_burst), .o_mem_ext_burst_size(o_mem_ext_burst_size),
    .o_mem_ext_paddr(o_mem_ext_paddr), .o_mem_ext_wdat(o_mem_ext_wdat),
    .i_ext_mmu_rdy(i_ext_mmu_rdy), .i_ext_mmu_rd_ack(i_ext_mmu_rd_ack),
    .i_ext_mmu_wr_ack(i_ext_mmu_wr_ack), .i_ext_mmu_rdat(i_ext_mmu_rdat)
  );

  always #5 clk = ~clk;

  // Packed view of every external-bus output: {rden,wren,start,end,vld,mask,burst,size,paddr,wdat}
  function automatic logic [186:0] got_ext();
    return {o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_burst_start, o_mem_ext_burst_end,
            o_mem_ext_burst_vld, o_mem_ext_mask, o_mem_ext_burst, o_mem_ext_burst_size,
            o_mem_ext_paddr, o_mem_ext_wdat};
  endfunction

  // Expected external bus for beat n of a line request.
  function automatic logic [186:0] exp_ext(input bit wr, input logic [31:0] pa,
                                           input logic [511:0] wd, input logic [63:0] mk,
                                           input int n);
    logic [31:0]  a;
    logic [127:0] d;
    logic [15:0]  m;
    a = (pa & 32'hFFFF_FFC0) + 32'(16 * n);
    d = wr ? wd[128*n +: 128] : 128'd0;
    m = wr ? mk[16*n +: 16] : 16'd0;
    return {1'(!wr && n == 0), 1'(wr && n == 0), 1'(n == 0), 1'(n == 3), 1'b1,
            m, 3'b011, 3'b100, a, d};
  endfunction

  task automatic skip(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a request and hold it until accepted (bounded); returns in beat 0.
  task automatic issue_req(input bit wr, input logic [31:0] pa,
                           input logic [511:0] wd, input logic [63:0] mk);
    int k;
    k = 0;
    i_ext_mmu_rdy = 1'b1;
    i_req_vld = 1'b1; i_req_wr = wr; i_req_paddr = pa; i_req_wdat = wd; i_req_mask = mk;
    @(negedge clk);
    while (!o_req_rdy && k < 20) begin @(negedge clk); k++; end
    if (!o_req_rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept_timeout got rdy=%b want 1", o_req_rdy);
    end
    @(posedge clk); #1;
    i_req_vld = 1'b0;
  endtask

  task automatic send_rd_acks(input logic [511:0] line);
    for (int k = 0; k < 4; k++) begin
      i_ext_mmu_rd_ack = 1'b1; i_ext_mmu_rdat = line[128*k +: 128];
      @(posedge clk); #1;
    end
    i_ext_mmu_rd_ack = 1'b0;
  endtask

  task automatic drain_rsp();
    i_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    i_rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req_vld = 1'b1; i_ext_mmu_rdy = 1'b1;
    skip(2);
    @(negedge clk);
    n_cmp++;
    if (o_req_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_req_rdy got %b want 0", o_req_rdy); end
    n_cmp++;
    if ({got_ext(), o_rsp_vld, o_rsp_wr, o_rsp_rdat} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got ext=%h rsp_vld=%b want all 0", got_ext(), o_rsp_vld);
    end
    @(posedge clk); #1;
    i_req_vld = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_req_rdy !== 1'b1) begin n_bad++; $display("FAIL idle_req_rdy got %b want 1", o_req_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [511:0] wd;
    logic [63:0]  mk;
    for (int n = 0; n < 4; n++) wd[128*n +: 128] = 128'(n + 1);
    mk = {$urandom, $urandom};
    issue_req(1'b1, 32'h1000_0047, wd, mk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_cmp++;
      if (got_ext() !== exp_ext(1'b1, 32'h1000_0047, wd, mk, n) ||
          o_mem_ext_paddr !== 32'h1000_0040 + 32'(16 * n)) begin
        n_bad++; $display("FAIL wr_beat%0d got %h want %h", n, got_ext(), exp_ext(1'b1, 32'h1000_0047, wd, mk, n));
      end
      @(posedge clk); #1;
    end
    i_ext_mmu_rd_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({o_rsp_vld, got_ext()} !== '0) begin
        n_bad++; $display("FAIL wr_wait_ignores_rd_ack got rsp_vld=%b ext=%h want 0", o_rsp_vld, got_ext());
      end
      @(posedge clk); #1;
    end
    i_ext_mmu_rd_ack = 1'b0; i_ext_mmu_wr_ack = 1'b1;
    @(posedge clk); #1;
    i_ext_mmu_wr_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_rsp_vld, o_rsp_wr, o_rsp_rdat} !== {1'b1, 1'b1, 512'd0}) begin
      n_bad++; $display("FAIL wr_rsp got vld=%b wr=%b want vld=1 wr=1", o_rsp_vld, o_rsp_wr);
    end
    drain_rsp();
  endtask

  task automatic test_read();
    logic [511:0] line;
    line = {{4{32'hDDDD_0004}}, {4{32'hCCCC_0003}}, {4{32'hBBBB_0002}}, {4{32'hAAAA_0001}}};
    issue_req(1'b0, 32'h2000_0000, {16{32'hFFFF_FFFF}}, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_cmp++;
      if (got_ext() !== exp_ext(1'b0, 32'h2000_0000, '0, '0, n)) begin
        n_bad++; $display("FAIL rd_beat%0d got %h want %h", n, got_ext(), exp_ext(1'b0, 32'h2000_0000, '0, '0, n));
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      i_ext_mmu_rd_ack = 1'b0; i_ext_mmu_rdat = '1;
      @(posedge clk); #1;
      i_ext_mmu_rd_ack = 1'b1; i_ext_mmu_rdat = line[128*k +: 128];
      @(posedge clk); #1;
    end
    i_ext_mmu_rd_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_rsp_vld, o_rsp_wr, o_rsp_rdat} !== {1'b1, 1'b0, line}) begin
      n_bad++; $display("FAIL rd_rsp got vld=%b wr=%b rdat=%h want rdat=%h", o_rsp_vld, o_rsp_wr, o_rsp_rdat, line);
    end
    drain_rsp();
  endtask

  task automatic test_mmu_backpressure();
    i_ext_mmu_rdy = 1'b0;
    i_req_vld = 1'b1; i_req_wr = 1'b0; i_req_paddr = 32'h3000_0080;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_req_rdy, o_mem_ext_burst_vld} !== 2'b00) begin
        n_bad++; $display("FAIL mmu_busy_c%0d got rdy=%b burst_vld=%b want 0 0", c, o_req_rdy, o_mem_ext_burst_vld);
      end
      @(posedge clk); #1;
    end
    i_ext_mmu_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_req_rdy !== 1'b1) begin n_bad++; $display("FAIL mmu_ready_rdy got %b want 1", o_req_rdy); end
    @(posedge clk); #1;
    i_req_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_mem_ext_burst_vld, o_mem_ext_burst_start, o_mem_ext_paddr} !== {2'b11, 32'h3000_0080}) begin
      n_bad++; $display("FAIL mmu_ready_beat0 got vld=%b start=%b paddr=%h want 1 1 30000080",
                        o_mem_ext_burst_vld, o_mem_ext_burst_start, o_mem_ext_paddr);
    end
    @(posedge clk); #1;
    skip(3);
    send_rd_acks('0);
    drain_rsp();
  endtask

  task automatic test_rsp_hold();
    logic [511:0] line;
    for (int w = 0; w < 16; w++) line[32*w +: 32] = $urandom;
    issue_req(1'b0, 32'h4000_0100, '0, '0);
    skip(4);
    send_rd_acks(line);
    for (int c = 0; c < 5; c++) begin
      i_ext_mmu_rd_ack = 1'b1; i_ext_mmu_rdat = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_cmp++;
      if ({o_rsp_vld, o_rsp_wr, o_rsp_rdat} !== {1'b1, 1'b0, line}) begin
        n_bad++; $display("FAIL rsp_hold_c%0d got vld=%b rdat=%h want %h", c, o_rsp_vld, o_rsp_rdat, line);
      end
      @(posedge clk); #1;
    end
    i_ext_mmu_rd_ack = 1'b0;
    i_rsp_rdy = 1'b1; i_req_vld = 1'b1; i_req_wr = 1'b0; i_req_paddr = 32'h4000_0200;
    @(negedge clk);
    n_cmp++;
    if (o_req_rdy !== 1'b0) begin n_bad++; $display("FAIL rsp_cycle_req_rdy got %b want 0", o_req_rdy); end
    @(posedge clk); #1;
    i_rsp_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_req_rdy, o_rsp_vld} !== 2'b10) begin
      n_bad++; $display("FAIL after_rsp got rdy=%b rsp_vld=%b want 1 0", o_req_rdy, o_rsp_vld);
    end
    @(posedge clk); #1;
    i_req_vld = 1'b0;
    skip(4);
    send_rd_acks('0);
    drain_rsp();
  endtask

  task automatic test_reset_midburst();
    logic [511:0] wd, line;
    for (int w = 0; w < 16; w++) begin wd[32*w +: 32] = $urandom; line[32*w +: 32] = $urandom; end
    issue_req(1'b1, 32'h5000_0000, wd, '1);
    skip(2);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (got_ext() !== exp_ext(1'b1, 32'h5000_0000, wd, '1, 2)) begin
      n_bad++; $display("FAIL rst_beat2 got %h want %h", got_ext(), exp_ext(1'b1, 32'h5000_0000, wd, '1, 2));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({got_ext(), o_rsp_vld, o_rsp_wr, o_rsp_rdat, o_req_rdy} !== {187'd0, 1'b0, 1'b0, 512'd0, 1'b1}) begin
        n_bad++; $display("FAIL post_rst_c%0d got ext=%h rsp_vld=%b rdy=%b want ext=0 rsp_vld=0 rdy=1",
                          c, got_ext(), o_rsp_vld, o_req_rdy);
      end
      @(posedge clk); #1;
    end
    issue_req(1'b0, 32'h5000_0040, '0, '0);
    skip(4);
    send_rd_acks(line);
    @(negedge clk);
    n_cmp++;
    if ({o_rsp_vld, o_rsp_wr, o_rsp_rdat} !== {1'b1, 1'b0, line}) begin
      n_bad++; $display("FAIL post_rst_read got vld=%b rdat=%h want %h", o_rsp_vld, o_rsp_rdat, line);
    end
    drain_rsp();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit           wr, good;
      logic [31:0]  pa;
      logic [511:0] wd, line;
      logic [63:0]  mk;
      int           nacks, gap, hold;
      wr = 1'($urandom % 2);
      pa = $urandom;
      for (int w = 0; w < 16; w++) wd[32*w +: 32] = $urandom;
      mk = {$urandom, $urandom};
      issue_req(wr, pa, wd, mk);
      i_req_paddr = $urandom; i_req_wdat = ~wd; i_req_mask = ~mk; i_req_wr = ~wr;
      for (int n = 0; n < 4; n++) begin
        i_ext_mmu_rd_ack = 1'($urandom % 2); i_ext_mmu_wr_ack = 1'($urandom % 2);
        i_ext_mmu_rdat = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        n_cmp++;
        if (got_ext() !== exp_ext(wr, pa, wd, mk, n)) begin
          n_bad++; $display("FAIL rand%0d_beat%0d got %h want %h", t, n, got_ext(), exp_ext(wr, pa, wd, mk, n));
        end
        @(posedge clk); #1;
      end
      line = '0;
      nacks = wr ? 1 : 4;
      for (int k = 0; k < nacks; k++) begin
        gap = int'($urandom % 3);
        for (int g = 0; g <= gap; g++) begin
          good = (g == gap);
          if (wr) begin i_ext_mmu_wr_ack = good; i_ext_mmu_rd_ack = 1'($urandom % 2); end
          else    begin i_ext_mmu_rd_ack = good; i_ext_mmu_wr_ack = 1'($urandom % 2); end
          i_ext_mmu_rdat = {$urandom, $urandom, $urandom, $urandom};
          if (!wr && good) line[128*k +: 128] = i_ext_mmu_rdat;
          @(negedge clk);
          n_cmp++;
          if ({o_rsp_vld, got_ext()} !== '0) begin
            n_bad++; $display("FAIL rand%0d_wait got rsp_vld=%b ext=%h want 0", t, o_rsp_vld, got_ext());
          end
          @(posedge clk); #1;
        end
      end
      i_ext_mmu_wr_ack = 1'b0;
      hold = int'($urandom % 3);
      for (int h = 0; h <= hold; h++) begin
        i_rsp_rdy = (h == hold);
        i_ext_mmu_rd_ack = 1'($urandom % 2);
        i_ext_mmu_rdat = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        n_cmp++;
        if ({o_rsp_vld, o_rsp_wr, o_rsp_rdat} !== {1'b1, wr, line}) begin
          n_bad++; $display("FAIL rand%0d_rsp got vld=%b wr=%b rdat=%h want vld=1 wr=%b rdat=%h",
                            t, o_rsp_vld, o_rsp_wr, o_rsp_rdat, wr, line);
        end
        @(posedge clk); #1;
      end
      i_rsp_rdy = 1'b0; i_ext_mmu_rd_ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req_vld = 1'b0; i_req_wr = 1'b0; i_req_paddr = '0; i_req_wdat = '0; i_req_mask = '0;
    i_rsp_rdy = 1'b0; i_ext_mmu_rdy = 1'b0; i_ext_mmu_rd_ack = 1'b0; i_ext_mmu_wr_ack = 1'b0;
    i_ext_mmu_rdat = '0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_mmu_backpressure();
    test_rsp_hold();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
